// File: rtl/riscv_lsu.sv
// RV32I load/store unit: loads 3 cycles, SW 2 cycles, SB/SH read-modify-write 4 cycles, errors 1 cycle to rsp_valid.
// One access in flight; req_ready only in IDLE. Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module riscv_lsu #(
   parameter logic [31:0] BASE = 32'h8000_0000,
   parameter int          AW   = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_fun3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_MRG  = 3'd2,
      S_WR   = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic          r_we;
   logic [2:0]    r_fun3;
   logic [1:0]    r_lane;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic [AW-1:0] r_mem_addr;
   logic [31:0]   r_mem_wdata;

   logic          w_accept;
   logic [AW-1:0] w_word_idx;
   logic          w_fun3_ok;
   logic          w_misalign;
   logic          w_err;
   logic [1:0]    w_lane;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_load_ext;
   logic [31:0]   w_merge;

   assign w_accept   = req_valid & req_ready;
   // Window-relative word index; out-of-window addresses simply wrap.
   assign w_word_idx = AW'((req_addr - BASE) >> 2);

   always_comb begin
      w_fun3_ok = 1'b0;
      if (req_we) begin
         w_fun3_ok = (req_fun3 == 3'b000) || (req_fun3 == 3'b001) || (req_fun3 == 3'b010);
      end else begin
         w_fun3_ok = (req_fun3 == 3'b000) || (req_fun3 == 3'b001) || (req_fun3 == 3'b010) ||
                     (req_fun3 == 3'b100) || (req_fun3 == 3'b101);
      end
   end

   assign w_misalign = ((req_fun3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_fun3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_err = !w_fun3_ok || w_misalign;
`else
   assign w_err = !w_fun3_ok;
`endif

   // Lane is force-aligned to the access width; in trap builds misaligned ones never use it.
   always_comb begin
      w_lane = req_addr[1:0];
      case (req_fun3[1:0])
         2'b01:   w_lane = {req_addr[1], 1'b0};
         2'b10:   w_lane = 2'b00;
         default: w_lane = req_addr[1:0];
      endcase
   end

   always_comb begin
      w_byte = mem_rdata[7:0];
      case (r_lane)
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         2'd3:    w_byte = mem_rdata[31:24];
         default: w_byte = mem_rdata[7:0];
      endcase
      w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   always_comb begin
      w_load_ext = mem_rdata;
      case (r_fun3)
         3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_ext = {24'd0, w_byte};
         3'b101:  w_load_ext = {16'd0, w_half};
         default: w_load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      w_merge = mem_rdata;
      if (r_fun3[1:0] == 2'b00) begin
         case (r_lane)
            2'd0:    w_merge[7:0]   = r_wdata[7:0];
            2'd1:    w_merge[15:8]  = r_wdata[7:0];
            2'd2:    w_merge[23:16] = r_wdata[7:0];
            default: w_merge[31:24] = r_wdata[7:0];
         endcase
      end else if (r_fun3[1:0] == 2'b01) begin
         if (r_lane[1]) begin
            w_merge[31:16] = r_wdata[15:0];
         end else begin
            w_merge[15:0]  = r_wdata[15:0];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_err) begin
                  w_next = S_RSP;
               end else if (req_we && (req_fun3[1:0] == 2'b10)) begin
                  w_next = S_WR;
               end else begin
                  w_next = S_RD;
               end
            end
         end
         S_RD:    w_next = S_MRG;
         S_MRG:   w_next = r_we ? S_WR : S_RSP;
         S_WR:    w_next = S_RSP;
         S_RSP:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_fun3      <= 3'd0;
         r_lane      <= 2'd0;
         r_wdata     <= 32'd0;
         r_rdata     <= 32'd0;
         r_err       <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we        <= req_we;
            r_fun3      <= req_fun3;
            r_lane      <= w_lane;
            r_wdata     <= req_wdata;
            r_rdata     <= 32'd0;
            r_err       <= w_err;
            r_mem_addr  <= w_word_idx;
            r_mem_wdata <= req_wdata;
         end else if (r_state == S_MRG) begin
            if (r_we) begin
               r_mem_wdata <= w_merge;
            end else begin
               r_rdata <= w_load_ext;
            end
         end
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign mem_re    = (r_state == S_RD);
   assign mem_we    = (r_state == S_WR);
   assign rsp_valid = (r_state == S_RSP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
